// File: rtl/ddr_cmd_decoder_pkg.sv
// ddr_cmd_decoder_pkg: shared types and sizes for the DDR4 command decoder.
//   dec_cmd_e  - decoded command code carried on the command queue.
//   dec_cmd_t  - one queued command: code, bank group, bank, payload.
//   ddr_pins_t - one registered sample of the command/address pin set.
package ddr_cmd_decoder_pkg;

    localparam int unsigned BG_WIDTH   = 2;
    localparam int unsigned BA_WIDTH   = 2;
    localparam int unsigned BANK_W     = BG_WIDTH + BA_WIDTH;
    localparam int unsigned NUM_BANKS  = 1 << BANK_W;
    localparam int unsigned ROW_W      = 15;
    localparam int unsigned CMD_ADDR_W = 18;

    typedef enum logic [3:0] {
        CmdAct     = 4'd0,
        CmdPre     = 4'd1,
        CmdPrea    = 4'd2,
        CmdCasR    = 4'd3,
        CmdCasW    = 4'd4,
        CmdMrs     = 4'd5,
        CmdRef     = 4'd6,
        CmdZqcl    = 4'd7,
        CmdDes     = 4'd8,
        CmdNop     = 4'd9,
        CmdIllegal = 4'd10
    } dec_cmd_e;

    typedef struct packed {
        dec_cmd_e                cmd_type;
        logic [BG_WIDTH-1:0]     bg;
        logic [BA_WIDTH-1:0]     ba;
        logic [CMD_ADDR_W-1:0]   addr;
    } dec_cmd_t;

    typedef struct packed {
        logic                cke;
        logic                cs_n;
        logic                act_n;
        logic                ras_n;
        logic                cas_n;
        logic                we_n;
        logic                a17;
        logic                a13;
        logic                a12;
        logic                a11;
        logic                a10;
        logic [9:0]          a9_0;
        logic [BG_WIDTH-1:0] bg;
        logic [BA_WIDTH-1:0] ba;
    } ddr_pins_t;

    // Reset value of the input register: a deselect with clock enable high.
    localparam ddr_pins_t PinsDes = '{cke: 1'b1, cs_n: 1'b1, default: '0};

    function automatic logic is_idle(dec_cmd_e c);
        return (c == CmdDes) || (c == CmdNop);
    endfunction

endpackage

// File: rtl/ddr_cmd_decoder_if.sv
// ddr_cmd_decoder_if: decoded-command stream between the decoder (master) and the
// memory model (slave).
//   cmd_valid  - head of queue valid          (master -> slave)
//   cmd_ready  - consumer accepts the head    (slave -> master)
//   cmd_type, cmd_bg, cmd_ba, cmd_addr - head command fields (master -> slave)
interface ddr_cmd_decoder_if;
    import ddr_cmd_decoder_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    dec_cmd_e              cmd_type;
    logic [BG_WIDTH-1:0]   cmd_bg;
    logic [BA_WIDTH-1:0]   cmd_ba;
    logic [CMD_ADDR_W-1:0] cmd_addr;

    modport master (
        output cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_addr,
        output cmd_ready
    );

endinterface

// File: rtl/ddr_cmd_decoder_fifo.sv
// ddr_cmd_fifo: synchronous FIFO of decoded commands.
//   clock_t, reset    - clock and synchronous active-high reset (flushes the queue)
//   push_i, wdata_i   - write request and data; accepted when not full or popping
//   pop_i             - read request; ignored while empty
//   rdata_o           - head entry
//   full_o, empty_o   - occupancy flags from a count one bit wider than the pointers
module ddr_cmd_fifo
    import ddr_cmd_decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clock_t,
    input  logic     reset,
    input  logic     push_i,
    input  dec_cmd_t wdata_i,
    input  logic     pop_i,
    output dec_cmd_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int unsigned      PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0]  PtrOne    = PtrW'(1);
    localparam logic [PtrW:0]    CntOne    = (PtrW + 1)'(1);
    localparam logic [PtrW:0]    FullCount = (PtrW + 1)'(DEPTH);

    dec_cmd_t        mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            push_en, pop_en;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign pop_en  = pop_i && !empty_o;
    // A same-cycle pop frees the slot, so a push into a full queue still lands.
    assign push_en = push_i && (!full_o || pop_en);
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clock_t) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push_en && !pop_en) begin
                count_q <= count_q + CntOne;
            end else if (pop_en && !push_en) begin
                count_q <= count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clock_t) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ddr_cmd_decoder.sv
// ddr_cmd_decoder: memory-side DDR4 command/address decoder.
//   clock_t, reset        - sampling clock, synchronous active-high reset
//   cke .. ap_a10, addr9_0, bg_addr, ba_addr - command/address pins, registered each edge
//   cmd_if (master)       - decoded-command queue head with valid/ready handshake
//   bank_open             - one bit per {bg,ba}: bank holds an open row
//   err_*                 - sticky protocol-violation flags, cleared only by reset
module ddr_cmd_decoder
    import ddr_cmd_decoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          KEEP_IDLE  = 1'b0
) (
    input  logic                 clock_t,
    input  logic                 reset,
    input  logic                 cke,
    input  logic                 cs_n,
    input  logic                 act_n,
    input  logic                 ras_n_a16,
    input  logic                 cas_n_a15,
    input  logic                 we_n_a14,
    input  logic                 addr17,
    input  logic                 addr13,
    input  logic                 bc_n_a12,
    input  logic                 addr11,
    input  logic                 ap_a10,
    input  logic [9:0]           addr9_0,
    input  logic [BG_WIDTH-1:0]  bg_addr,
    input  logic [BA_WIDTH-1:0]  ba_addr,
    ddr_cmd_decoder_if.master    cmd_if,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 err_act_open,
    output logic                 err_cas_closed,
    output logic                 err_ref_open,
    output logic                 err_illegal,
    output logic                 err_overflow
);
    // Stage 1: pin register. smp_vld_q keeps the reset-time DES out of the queue.
    ddr_pins_t pins_q;
    logic      smp_vld_q;

    always_ff @(posedge clock_t) begin
        if (reset) begin
            pins_q    <= PinsDes;
            smp_vld_q <= 1'b0;
        end else begin
            pins_q    <= {cke, cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14, addr17, addr13,
                          bc_n_a12, addr11, ap_a10, addr9_0, bg_addr, ba_addr};
            smp_vld_q <= 1'b1;
        end
    end

    // Stage 2: decode.
    dec_cmd_t dec_cmd;
    logic     dec_vld;

    always_comb begin
        dec_vld = 1'b0;
        dec_cmd = '{cmd_type: CmdIllegal, bg: pins_q.bg, ba: pins_q.ba, addr: '0};
        if (smp_vld_q && pins_q.cke) begin
            dec_vld = 1'b1;
            if ($isunknown(pins_q.cs_n)) begin
                dec_cmd.cmd_type = CmdIllegal;
            end else if (pins_q.cs_n) begin
                dec_cmd.cmd_type = CmdDes;
            end else if ($isunknown({pins_q.act_n, pins_q.ras_n, pins_q.cas_n, pins_q.we_n,
                                     pins_q.a10})) begin
                dec_cmd.cmd_type = CmdIllegal;
            end else if (!pins_q.act_n) begin
                dec_cmd.cmd_type = CmdAct;
                dec_cmd.addr     = {3'b000, pins_q.we_n, pins_q.a13, pins_q.a12, pins_q.a11,
                                    pins_q.a10, pins_q.a9_0};
            end else begin
                case ({pins_q.ras_n, pins_q.cas_n, pins_q.we_n})
                    3'b111: dec_cmd.cmd_type = CmdNop;
                    3'b010: dec_cmd.cmd_type = pins_q.a10 ? CmdPrea : CmdPre;
                    3'b101: begin
                        dec_cmd.cmd_type = CmdCasR;
                        dec_cmd.addr     = {8'h00, pins_q.a9_0};
                    end
                    3'b100: begin
                        dec_cmd.cmd_type = CmdCasW;
                        dec_cmd.addr     = {8'h00, pins_q.a9_0};
                    end
                    3'b000: begin
                        dec_cmd.cmd_type = CmdMrs;
                        dec_cmd.addr     = {pins_q.a17, pins_q.ras_n, pins_q.cas_n,
                                            pins_q.we_n, pins_q.a13, pins_q.a12, pins_q.a11,
                                            pins_q.a10, pins_q.a9_0};
                    end
                    3'b001:  dec_cmd.cmd_type = CmdRef;
                    3'b110:  dec_cmd.cmd_type = pins_q.a10 ? CmdZqcl : CmdIllegal;
                    default: dec_cmd.cmd_type = CmdIllegal;
                endcase
            end
        end
    end

    // Bank table and sticky error flags.
    logic [BANK_W-1:0]                open_idx;
    logic [NUM_BANKS-1:0]             open_q, open_d;
    logic [NUM_BANKS-1:0][ROW_W-1:0]  row_q, row_d;
    logic err_act_q, err_act_d, err_cas_q, err_cas_d, err_ref_q, err_ref_d;
    logic err_ill_q, err_ill_d, err_ovf_q, err_ovf_d;
    logic push, fifo_full, fifo_empty;

    assign open_idx = {pins_q.bg, pins_q.ba};
    assign push     = dec_vld && (KEEP_IDLE || !is_idle(dec_cmd.cmd_type));

    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        err_act_d = err_act_q;
        err_cas_d = err_cas_q;
        err_ref_d = err_ref_q;
        err_ill_d = err_ill_q;
        err_ovf_d = err_ovf_q;
        if (dec_vld) begin
            case (dec_cmd.cmd_type)
                CmdAct: begin
                    if (open_q[open_idx]) err_act_d = 1'b1;
                    open_d[open_idx] = 1'b1;
                    row_d[open_idx]  = dec_cmd.addr[ROW_W-1:0];
                end
                CmdPre:           open_d[open_idx] = 1'b0;
                CmdPrea:          open_d = '0;
                CmdCasR, CmdCasW: if (!open_q[open_idx]) err_cas_d = 1'b1;
                CmdRef:           if (|open_q) err_ref_d = 1'b1;
                CmdIllegal:       err_ill_d = 1'b1;
                default:          ;
            endcase
        end
        // Full with no pop this edge: the command is lost, the table update above stands.
        if (push && fifo_full && !cmd_if.cmd_ready) err_ovf_d = 1'b1;
    end

    always_ff @(posedge clock_t) begin
        if (reset) begin
            open_q    <= '0;
            row_q     <= '0;
            err_act_q <= 1'b0;
            err_cas_q <= 1'b0;
            err_ref_q <= 1'b0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            open_q    <= open_d;
            row_q     <= row_d;
            err_act_q <= err_act_d;
            err_cas_q <= err_cas_d;
            err_ref_q <= err_ref_d;
            err_ill_q <= err_ill_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // Command queue.
    dec_cmd_t fifo_rdata, head;

    ddr_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock_t(clock_t),
        .reset  (reset),
        .push_i (push),
        .wdata_i(dec_cmd),
        .pop_i  (cmd_if.cmd_ready),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Head fields read as zero while the queue is empty.
    assign head             = fifo_empty ? '0 : fifo_rdata;
    assign cmd_if.cmd_valid = !fifo_empty;
    assign cmd_if.cmd_type  = head.cmd_type;
    assign cmd_if.cmd_bg    = head.bg;
    assign cmd_if.cmd_ba    = head.ba;
    assign cmd_if.cmd_addr  = head.addr;

    assign bank_open      = open_q;
    assign err_act_open   = err_act_q;
    assign err_cas_closed = err_cas_q;
    assign err_ref_open   = err_ref_q;
    assign err_illegal    = err_ill_q;
    assign err_overflow   = err_ovf_q;

endmodule
